// File: rtl/palette_pkg.sv
// Shared types for the palette scene-fade controller.
// Fade FSM states, RGB bundle and scene identifiers.
package palette_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        HOLD,
        SWAP,
        FADE_IN
    } fade_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic SCENE_AREA   = 1'b0;
    localparam logic SCENE_FOREST = 1'b1;

endpackage

// File: rtl/rgb_scale.sv
// One colour channel scaled by the fade level.
// Purely combinational; the caller registers the result.
module rgb_scale #(
    parameter int LOG2_STEPS = 3
) (
    input  logic [7:0]          chan,
    input  logic [LOG2_STEPS:0] level,
    output logic [7:0]          scaled
);

    logic [8+LOG2_STEPS:0] prod;

    assign prod   = chan * level;
    // level never exceeds 2**LOG2_STEPS, so the shifted product fits 8 bits
    assign scaled = 8'(prod >> LOG2_STEPS);

endmodule

// File: rtl/palette_fade_ctrl.sv
// Scene-transition controller: fade to black, swap palette, fade back in.
// Sits between the palette ROM outputs and the VGA colour pins.
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int LOG2_STEPS      = 3,
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       target_scene,
    input  logic       video_on,
    input  logic [7:0] area_r,
    input  logic [7:0] area_g,
    input  logic [7:0] area_b,
    input  logic [7:0] forest_r,
    input  logic [7:0] forest_g,
    input  logic [7:0] forest_b,
    output logic       scene_sel,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       busy,
    output logic       done
);

    localparam int LW   = LOG2_STEPS + 1;
    localparam int CMAX = (FRAMES_PER_STEP > HOLD_FRAMES) ?
                          FRAMES_PER_STEP : HOLD_FRAMES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [LW-1:0] FULL      = LW'(2 ** LOG2_STEPS);
    localparam logic [CW-1:0] STEP_LAST = CW'(FRAMES_PER_STEP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

    fade_state_t   state;
    fade_state_t   state_nx;
    logic [LW-1:0] level;
    logic [CW-1:0] frame_cnt;
    logic          target;
    logic          step_tick;
    logic          tick_en;
    logic          lvl_dn;
    logic          lvl_up;
    logic          swap_now;
    rgb_t          sel;
    rgb_t          scaled;

    assign step_tick = frame_tick && (frame_cnt == STEP_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (start && (target_scene != scene_sel))
                    state_nx = FADE_OUT;
            FADE_OUT:
                if (step_tick && (level == LW'(1)))
                    state_nx = HOLD;
            HOLD:
                if (frame_tick && (frame_cnt == HOLD_LAST))
                    state_nx = SWAP;
            SWAP:
                state_nx = FADE_IN;
            FADE_IN:
                if (step_tick && (level == FULL - LW'(1)))
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b1;
        tick_en  = 1'b0;
        lvl_dn   = 1'b0;
        lvl_up   = 1'b0;
        swap_now = 1'b0;
        unique case (state)
            IDLE:     busy = 1'b0;
            FADE_OUT: begin
                tick_en = frame_tick;
                lvl_dn  = step_tick;
            end
            HOLD:     tick_en = frame_tick;
            SWAP:     swap_now = 1'b1;
            FADE_IN:  begin
                tick_en = frame_tick;
                lvl_up  = step_tick;
            end
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level     <= FULL;
            frame_cnt <= '0;
            target    <= SCENE_AREA;
            scene_sel <= SCENE_AREA;
            done      <= 1'b0;
        end else begin
            done <= (state == FADE_IN) && (state_nx == IDLE);
            if ((state == IDLE) && (state_nx == FADE_OUT))
                target <= target_scene;
            if (swap_now)
                scene_sel <= target;
            if (lvl_dn)
                level <= level - LW'(1);
            else if (lvl_up)
                level <= level + LW'(1);
            // new state starts counting from zero; entry-cycle tick still counts
            if (state_nx != state)
                frame_cnt <= '0;
            else if (tick_en)
                frame_cnt <= (lvl_dn || lvl_up) ? '0 : frame_cnt + CW'(1);
        end
    end

    always_comb begin
        sel = (scene_sel == SCENE_FOREST) ?
              '{r: forest_r, g: forest_g, b: forest_b} :
              '{r: area_r, g: area_g, b: area_b};
    end

    rgb_scale #(.LOG2_STEPS(LOG2_STEPS)) u_scale_r (
        .chan   (sel.r),
        .level  (level),
        .scaled (scaled.r)
    );

    rgb_scale #(.LOG2_STEPS(LOG2_STEPS)) u_scale_g (
        .chan   (sel.g),
        .level  (level),
        .scaled (scaled.g)
    );

    rgb_scale #(.LOG2_STEPS(LOG2_STEPS)) u_scale_b (
        .chan   (sel.b),
        .level  (level),
        .scaled (scaled.b)
    );

    always_ff @(posedge Clk) begin
        if (Reset || !video_on) begin
            VGA_R <= 8'h00;
            VGA_G <= 8'h00;
            VGA_B <= 8'h00;
        end else begin
            VGA_R <= scaled.r;
            VGA_G <= scaled.g;
            VGA_B <= scaled.b;
        end
    end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Scoreboard bench for palette_fade_ctrl.
// Reference model works from transition tick counts, not FSM states.
module tb_palette_fade_ctrl;

    localparam int L      = 3;
    localparam int FPS    = 2;
    localparam int HOLDF  = 4;
    localparam int FULLV  = 1 << L;
    localparam int OUT_T  = FULLV * FPS;
    localparam int HOLD_T = OUT_T + HOLDF;
    localparam int END_T  = HOLD_T + FULLV * FPS;

    logic       clk = 1'b0;
    logic       rst, tick, start, tgt, video;
    logic [7:0] ar, ag, ab, fr, fg, fb;
    logic       scene_sel, busy, done;
    logic [7:0] vr, vg, vb;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        bit         busy;
        bit         done;
        bit         scene;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    bit m_busy, m_scene, m_tgt, m_swap, m_in, m_done;
    int m_tc;

    always #5 clk = ~clk;

    palette_fade_ctrl #(
        .LOG2_STEPS      (L),
        .FRAMES_PER_STEP (FPS),
        .HOLD_FRAMES     (HOLDF)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .frame_tick   (tick),
        .start        (start),
        .target_scene (tgt),
        .video_on     (video),
        .area_r       (ar),
        .area_g       (ag),
        .area_b       (ab),
        .forest_r     (fr),
        .forest_g     (fg),
        .forest_b     (fb),
        .scene_sel    (scene_sel),
        .VGA_R        (vr),
        .VGA_G        (vg),
        .VGA_B        (vb),
        .busy         (busy),
        .done         (done)
    );

    // fade level implied by how many ticks the transition has consumed
    function automatic int m_level();
        if (!m_busy) return FULLV;
        if (!m_in) return (m_tc >= OUT_T) ? 0 : FULLV - m_tc / FPS;
        return (m_tc - HOLD_T) / FPS;
    endfunction

    task automatic model_step();
        exp_t       e;
        int         lv;
        logic [7:0] sr, sg, sb;
        lv = m_level();
        sr = m_scene ? fr : ar;
        sg = m_scene ? fg : ag;
        sb = m_scene ? fb : ab;
        if (rst || !video) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        end else begin
            e.r = 8'((int'(sr) * lv) / FULLV);
            e.g = 8'((int'(sg) * lv) / FULLV);
            e.b = 8'((int'(sb) * lv) / FULLV);
        end
        if (rst) begin
            m_busy = 0; m_scene = 0; m_tgt = 0;
            m_tc = 0; m_swap = 0; m_in = 0; m_done = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (start && (tgt != m_scene)) begin
                m_busy = 1; m_tgt = tgt; m_tc = 0;
                m_swap = 0; m_in = 0;
            end
        end else if (m_swap) begin
            m_scene = m_tgt; m_swap = 0; m_in = 1; m_done = 0;
        end else begin
            m_done = 0;
            if (tick) begin
                m_tc++;
                if (!m_in && m_tc == HOLD_T) begin
                    m_swap = 1;
                end else if (m_in && m_tc == END_T) begin
                    m_busy = 0; m_done = 1; m_in = 0;
                end
            end
        end
        e.busy  = m_busy;
        e.done  = m_done;
        e.scene = m_scene;
        q.push_back(e);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({vr, vg, vb} !== {e.r, e.g, e.b}) begin
                errors++;
                $display("FAIL pixel t=%0t got %h/%h/%h exp %h/%h/%h",
                         $time, vr, vg, vb, e.r, e.g, e.b);
            end
            checks++;
            if ({busy, done, scene_sel} !== {e.busy, e.done, e.scene}) begin
                errors++;
                $display("FAIL ctrl t=%0t got busy%0b done%0b scene%0b exp busy%0b done%0b scene%0b",
                         $time, busy, done, scene_sel, e.busy, e.done, e.scene);
            end
        end
    end

    initial begin
        m_busy = 0; m_scene = 0; m_tgt = 0;
        m_tc = 0; m_swap = 0; m_in = 0; m_done = 0;
        rst = 1; tick = 0; start = 0; tgt = 0; video = 1;
        ar = 8'hF0; ag = 8'hA0; ab = 8'h10;
        fr = 8'hF8; fg = 8'hF8; fb = 8'hD8;
        cyc();
        rst = 0;
        repeat (3) cyc();

        // full transition to forest; start shares a cycle with a tick
        for (int i = 0; i < 100; i++) begin
            tick  = (i % 2 == 0);
            start = (i == 0) || (i == 50);
            tgt   = (i == 0);
            video = (i % 7 != 3);
            cyc();
        end
        tick = 0; start = 0;

        // request for the scene already shown
        start = 1; tgt = 1;
        repeat (3) cyc();
        start = 0;
        cyc();

        // reset partway through a fade-out
        start = 1; tgt = 0;
        cyc();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            tick = 1;
            cyc();
        end
        tick = 0;
        rst = 1;
        cyc();
        rst = 0;
        repeat (3) cyc();

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 19) == 0);
            tgt   = 1'($urandom_range(0, 1));
            video = ($urandom_range(0, 7) != 0);
            ar = 8'($urandom); ag = 8'($urandom); ab = 8'($urandom);
            fr = 8'($urandom); fg = 8'($urandom); fb = 8'($urandom);
            cyc();
        end
        rst = 0; tick = 0; start = 0;
        @(negedge clk);
        @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
